// File: rtl/riscv_wb_arbiter_if.sv
// Bundle between the writeback arbiter and its neighbours: ALU result, LSU
// result FIFO handshake, LSU issue, decode hazard query, regfile write port
// and scoreboard view. The WB_FWD_EN build adds the raw regfile read data
// and the forwarded operand outputs.
interface riscv_wb_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_issue_valid;
  logic [4:0]  lsu_issue_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        dec_stall;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [31:0] busy;
`ifdef WB_FWD_EN
  logic [31:0] rd1_in;
  logic [31:0] rd2_in;
  logic [31:0] rd1_fwd;
  logic [31:0] rd2_fwd;
`endif

  // Arbiter side
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data, lsu_issue_valid, lsu_issue_rd,
    input  dec_rs1, dec_rs2, dec_rd,
    output lsu_ready, dec_stall, we3, a3, wd3, busy
`ifdef WB_FWD_EN
    , input rd1_in, rd2_in
    , output rd1_fwd, rd2_fwd
`endif
  );

  // Pipeline / testbench side
  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data, lsu_issue_valid, lsu_issue_rd,
    output dec_rs1, dec_rs2, dec_rd,
    input  lsu_ready, dec_stall, we3, a3, wd3, busy
`ifdef WB_FWD_EN
    , output rd1_in, rd2_in
    , input rd1_fwd, rd2_fwd
`endif
  );
endinterface

// File: rtl/riscv_wb_arbiter.sv
// Writeback arbiter in front of the regfile write port. ALU results always
// win; LSU results queue in a small FIFO and drain when the ALU is idle.
// A busy scoreboard tracks outstanding LSU destinations for decode stalls.
// Optional build macro WB_FWD_EN: clears busy bits in the we3 cycle and
// forwards the write port onto the decode operands.
module riscv_wb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input logic               clk,
  input logic               rst_n,
  riscv_wb_arbiter_if.slave wb
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  logic [4:0]     rd_mem_q   [FIFO_DEPTH];
  logic [31:0]    data_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0] count_q, count_d;
  logic           full, push, pop;

  logic           sel_valid;
  logic [4:0]     sel_rd;
  logic [31:0]    sel_data;

  logic           we3_q;
  logic [4:0]     a3_q;
  logic [31:0]    wd3_q;
  logic [31:0]    busy_q, busy_d;
  logic           clr_valid;
  logic [4:0]     clr_rd;

  assign full = (count_q == DEPTH_C);
  // A full FIFO refuses a push even when a pop frees a slot this cycle.
  assign push = wb.lsu_valid && !full;
  assign pop  = !wb.alu_valid && (count_q != '0);

  assign wb.lsu_ready = !full;

  // Source select for the write port registered at the next edge
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (wb.alu_valid) begin
      sel_valid = 1'b1;
      sel_rd    = wb.alu_rd;
      sel_data  = wb.alu_data;
    end else if (pop) begin
      sel_valid = 1'b1;
      sel_rd    = rd_mem_q[rd_ptr_q];
      sel_data  = data_mem_q[rd_ptr_q];
    end
  end

  // FIFO occupancy next value
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + (PTR_W+1)'(1);
    else if (!push && pop) count_d = count_q - (PTR_W+1)'(1);
  end

  // FIFO storage; contents need no reset because the pointers gate them
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wr_ptr_q]   <= wb.lsu_rd;
      data_mem_q[wr_ptr_q] <= wb.lsu_data;
    end
  end

  // FIFO pointers and count; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Registered regfile write port; x0 targets are suppressed here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3_q <= 1'b0;
      a3_q  <= '0;
      wd3_q <= '0;
    end else begin
      we3_q <= sel_valid && (sel_rd != 5'd0);
      if (sel_valid) begin
        a3_q  <= sel_rd;
        wd3_q <= sel_data;
      end
    end
  end

`ifdef WB_FWD_EN
  // Busy bit drops at the same edge the entry reaches we3
  assign clr_valid = pop;
  assign clr_rd    = rd_mem_q[rd_ptr_q];

  assign wb.rd1_fwd = (we3_q && (a3_q == wb.dec_rs1) && (wb.dec_rs1 != 5'd0)) ? wd3_q : wb.rd1_in;
  assign wb.rd2_fwd = (we3_q && (a3_q == wb.dec_rs2) && (wb.dec_rs2 != 5'd0)) ? wd3_q : wb.rd2_in;
`else
  logic lsu_wr_q;

  // Remember that the current we3 carries an LSU entry, so its busy bit
  // drops only after the regfile has committed it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lsu_wr_q <= 1'b0;
    else        lsu_wr_q <= pop;
  end

  assign clr_valid = lsu_wr_q;
  assign clr_rd    = a3_q;
`endif

  // Scoreboard next value; a new issue beats a same-cycle clear
  always_comb begin
    busy_d = busy_q;
    if (clr_valid) busy_d[clr_rd] = 1'b0;
    if (wb.lsu_issue_valid && (wb.lsu_issue_rd != 5'd0)) busy_d[wb.lsu_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign wb.dec_stall = busy_q[wb.dec_rs1] | busy_q[wb.dec_rs2] | busy_q[wb.dec_rd];
  assign wb.we3       = we3_q;
  assign wb.a3        = a3_q;
  assign wb.wd3       = wd3_q;
  assign wb.busy      = busy_q;

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Self-checking bench for riscv_wb_arbiter: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_riscv_wb_arbiter;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_wb_arbiter_if wb ();

  riscv_wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wb)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  bit          m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;
  logic [31:0] m_busy;
  bit          m_pend_v;
  logic [4:0]  m_pend_rd;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_we      = 1'b0;
    m_a3      = '0;
    m_wd      = '0;
    m_busy    = '0;
    m_pend_v  = 1'b0;
    m_pend_rd = '0;
  endtask

  task automatic set_idle();
    wb.alu_valid       = 1'b0;
    wb.alu_rd          = '0;
    wb.alu_data        = '0;
    wb.lsu_valid       = 1'b0;
    wb.lsu_rd          = '0;
    wb.lsu_data        = '0;
    wb.lsu_issue_valid = 1'b0;
    wb.lsu_issue_rd    = '0;
    wb.dec_rs1         = '0;
    wb.dec_rs2         = '0;
    wb.dec_rd          = '0;
`ifdef WB_FWD_EN
    wb.rd1_in          = '0;
    wb.rd2_in          = '0;
`endif
  endtask

  task automatic check_outputs();
    logic exp_stall;
    exp_stall = m_busy[wb.dec_rs1] | m_busy[wb.dec_rs2] | m_busy[wb.dec_rd];
    check("we3", wb.we3, m_we);
    if (m_we) begin
      check("a3", wb.a3, m_a3);
      check("wd3", wb.wd3, m_wd);
    end
    check("busy", wb.busy, m_busy);
    check("lsu_ready", wb.lsu_ready, m_q.size() != DEPTH);
    check("dec_stall", wb.dec_stall, exp_stall);
`ifdef WB_FWD_EN
    check("rd1_fwd", wb.rd1_fwd,
          (m_we && m_a3 == wb.dec_rs1 && wb.dec_rs1 != 0) ? m_wd : wb.rd1_in);
    check("rd2_fwd", wb.rd2_fwd,
          (m_we && m_a3 == wb.dec_rs2 && wb.dec_rs2 != 0) ? m_wd : wb.rd2_in);
`endif
  endtask

  // One clock edge of the reference behaviour, using the inputs held across it
  task automatic model_edge();
    ent_t        popped;
    bit          did_pop;
    bit          ready;
    logic [31:0] nb;
    did_pop = 1'b0;
    popped.rd = '0;
    popped.data = '0;
    ready = (m_q.size() != DEPTH);
    if (wb.alu_valid) begin
      m_we = (wb.alu_rd != 0);
      m_a3 = wb.alu_rd;
      m_wd = wb.alu_data;
    end else if (m_q.size() > 0) begin
      popped  = m_q.pop_front();
      did_pop = 1'b1;
      m_we = (popped.rd != 0);
      m_a3 = popped.rd;
      m_wd = popped.data;
    end else begin
      m_we = 1'b0;
    end
    if (wb.lsu_valid && ready) begin
      ent_t e;
      e.rd = wb.lsu_rd;
      e.data = wb.lsu_data;
      m_q.push_back(e);
    end
    nb = m_busy;
`ifdef WB_FWD_EN
    if (did_pop) nb[popped.rd] = 1'b0;
`else
    if (m_pend_v) nb[m_pend_rd] = 1'b0;
    m_pend_v  = did_pop;
    m_pend_rd = popped.rd;
`endif
    if (wb.lsu_issue_valid && wb.lsu_issue_rd != 0) nb[wb.lsu_issue_rd] = 1'b1;
    nb[0] = 1'b0;
    m_busy = nb;
  endtask

  // Called at a falling edge with inputs already driven
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_we3", wb.we3, 1'b0);
    check("rst_busy", wb.busy, 32'h0);
    check("rst_ready", wb.lsu_ready, 1'b1);
    @(negedge clk);
    set_idle();
    rst_n = 1'b1;
  endtask

  initial begin
    int pushed;
    int cyc;
    set_idle();
    model_reset();
    @(negedge clk);
    do_reset();
    step();

    // ALU path, including x0 suppression
    wb.alu_valid = 1'b1; wb.alu_rd = 5'd5; wb.alu_data = 32'hDEADBEEF;
    step();
    set_idle();
    #1;
    check("alu_we3", wb.we3, 1'b1);
    check("alu_a3", wb.a3, 32'd5);
    check("alu_wd3", wb.wd3, 32'hDEADBEEF);
    step();
    wb.alu_valid = 1'b1; wb.alu_rd = 5'd0; wb.alu_data = 32'h12345678;
    step();
    set_idle();
    step();
    step();

    // ALU burst while LSU pushes five results into a four-deep FIFO
    pushed = 0;
    cyc = 0;
    while ((pushed < 5 || m_q.size() != 0) && cyc < 40) begin
      bit acc;
      set_idle();
      wb.alu_valid = (cyc < 6);
      wb.alu_rd    = 5'(20 + cyc);
      wb.alu_data  = 32'hA000_0000 + 32'(cyc);
      if (pushed < 5) begin
        wb.lsu_valid = 1'b1;
        wb.lsu_rd    = 5'(10 + pushed);
        wb.lsu_data  = 32'h100 + 32'(pushed);
      end
      acc = wb.lsu_valid && (m_q.size() != DEPTH);
      step();
      if (acc) pushed++;
      cyc++;
    end
    check("contention_drained", (cyc < 40), 1'b1);
    set_idle();
    step();
    step();

    // Scoreboard set, stall and clear timing
    wb.lsu_issue_valid = 1'b1; wb.lsu_issue_rd = 5'd7;
    step();
    set_idle();
    wb.dec_rs2 = 5'd7;
    #1;
    check("stall_rs2_7", wb.dec_stall, 1'b1);
    wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd7; wb.lsu_data = 32'h1234;
    step();
    wb.lsu_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("busy7_cleared", wb.busy[7], 1'b0);

    // Set/clear collision on rd=9
    wb.lsu_issue_valid = 1'b1; wb.lsu_issue_rd = 5'd9;
    step();
    set_idle();
    wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd9; wb.lsu_data = 32'h99;
    step();
    set_idle();
`ifdef WB_FWD_EN
    wb.lsu_issue_valid = 1'b1; wb.lsu_issue_rd = 5'd9;
`endif
    step();
    set_idle();
`ifndef WB_FWD_EN
    wb.lsu_issue_valid = 1'b1; wb.lsu_issue_rd = 5'd9;
`endif
    step();
    set_idle();
    step();
    step();
    check("collide_busy9", wb.busy[9], 1'b1);

`ifdef WB_FWD_EN
    // Forwarding onto decode operands
    wb.alu_valid = 1'b1; wb.alu_rd = 5'd3; wb.alu_data = 32'hA5A5A5A5;
    step();
    set_idle();
    wb.dec_rs1 = 5'd3; wb.rd1_in = 32'h0;
    #1;
    check("fwd_rs1_3", wb.rd1_fwd, 32'hA5A5A5A5);
    wb.alu_valid = 1'b1; wb.alu_rd = 5'd3; wb.alu_data = 32'hA5A5A5A5;
    step();
    set_idle();
    wb.dec_rs1 = 5'd0; wb.rd1_in = 32'h0000_5555;
    #1;
    check("fwd_rs1_0", wb.rd1_fwd, 32'h0000_5555);
    step();
`endif

    // Mid-stream reset with three entries held in the FIFO
    set_idle();
    for (int i = 0; i < 3; i++) begin
      wb.alu_valid = 1'b1; wb.alu_rd = 5'd1; wb.alu_data = 32'(i);
      wb.lsu_valid = 1'b1; wb.lsu_rd = 5'(12 + i); wb.lsu_data = 32'hBB00 + 32'(i);
      wb.lsu_issue_valid = 1'b1; wb.lsu_issue_rd = 5'(12 + i);
      step();
    end
    check("pre_reset_fill", m_q.size(), 32'd3);
    do_reset();
    for (int i = 0; i < 4; i++) step();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        wb.alu_valid       = ($urandom_range(0, 99) < 45);
        wb.alu_rd          = 5'($urandom_range(0, 31));
        wb.alu_data        = $urandom;
        wb.lsu_valid       = ($urandom_range(0, 99) < 50);
        wb.lsu_rd          = 5'($urandom_range(0, 15));
        wb.lsu_data        = $urandom;
        wb.lsu_issue_valid = ($urandom_range(0, 99) < 30);
        wb.lsu_issue_rd    = 5'($urandom_range(0, 15));
        wb.dec_rs1         = 5'($urandom_range(0, 15));
        wb.dec_rs2         = 5'($urandom_range(0, 15));
        wb.dec_rd          = 5'($urandom_range(0, 15));
`ifdef WB_FWD_EN
        wb.rd1_in          = $urandom;
        wb.rd2_in          = $urandom;
`endif
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
